// File: rtl/mux2_1_arb_pkg.sv
// Shared definitions for the frame-aware 2:1 AXIS merger: FSM encoding,
// arbitration mode constants and the winner-selection rule.
package mux2_1_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Returns the winning slave index; only meaningful when at least one input is valid.
  function automatic logic pick_winner(input int mode, input logic v0, input logic v1,
                                       input logic last);
    if (mode == ARB_FIXED) return !v0;
    if (v0 && v1) return !last;
    return v1;
  endfunction

endpackage

// File: rtl/mux2_1_arb_axis_skid_buf.sv
// Two-entry AXIS register slice (main + skid). in_tready is a pure flop output,
// so upstream ready never sees out_tready combinationally.
module axis_skid_buf #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] in_tdata,
  input  logic             in_tvalid,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic [width-1:0] out_tdata,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready
);

  logic [width:0] main_q;
  logic [width:0] skid_q;
  logic           main_vld;
  logic           skid_vld;
  logic           pop;
  logic           push;

  assign in_tready  = !skid_vld;
  assign pop        = main_vld && out_tready;
  assign push       = in_tvalid && !skid_vld;
  assign out_tvalid = main_vld;
  assign out_tlast  = main_q[width];
  assign out_tdata  = main_q[width-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      // Full: no intake; drain the skid into main as soon as main is taken.
      if (pop) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (push) begin
      if (!main_vld || pop) begin
        main_q   <= {in_tlast, in_tdata};
        main_vld <= 1'b1;
      end else begin
        skid_vld <= 1'b1;
      end
    end else if (pop) begin
      main_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && main_vld && !pop) skid_q <= {in_tlast, in_tdata};
  end

endmodule

// File: rtl/mux2_1_arb.sv
// Frame-aware 2:1 AXIS merger: per-frame arbitration (round-robin or fixed
// priority) feeding a registered skid output stage.
module mux2_1_arb
  import mux2_1_arb_pkg::*;
#(
  parameter int width    = 1,
  parameter int arb_mode = ARB_RR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [width-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             grant,
  output logic             busy
);

  arb_state_t       state;
  logic             last_grant;
  logic             in_rdy;
  logic             sel_vld;
  logic             sel_last;
  logic [width-1:0] sel_data;
  logic             win;

  assign win            = pick_winner(arb_mode, s0_axis_tvalid, s1_axis_tvalid, last_grant);
  assign s0_axis_tready = (state == ST_LOCK0) && in_rdy;
  assign s1_axis_tready = (state == ST_LOCK1) && in_rdy;

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    case (state)
      ST_LOCK0: begin
        sel_vld  = s0_axis_tvalid;
        sel_last = s0_axis_tlast;
        sel_data = s0_axis_tdata;
      end
      ST_LOCK1: begin
        sel_vld  = s1_axis_tvalid;
        sel_last = s1_axis_tlast;
        sel_data = s1_axis_tdata;
      end
      default: ;
    endcase
  end

  // The lock is released on the edge that accepts the granted input's tlast beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            state <= win ? ST_LOCK1 : ST_LOCK0;
            grant <= win;
            busy  <= 1'b1;
          end
        end
        ST_LOCK0: begin
          if (s0_axis_tvalid && in_rdy && s0_axis_tlast) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= 1'b0;
          end
        end
        ST_LOCK1: begin
          if (s1_axis_tvalid && in_rdy && s1_axis_tlast) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            last_grant <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  axis_skid_buf #(.width(width)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (sel_data),
    .in_tvalid  (sel_vld),
    .in_tlast   (sel_last),
    .in_tready  (in_rdy),
    .out_tdata  (m_axis_tdata),
    .out_tvalid (m_axis_tvalid),
    .out_tlast  (m_axis_tlast),
    .out_tready (m_axis_tready)
  );

endmodule
